tcnt_updown: RTL and testbench

Parametrised up/down timer counter; next generation of the 8-bit TCNT.
- Adds configurable width, a count direction, and an auto-reload register.
- Produces separate overflow and underflow pulses.
- Sits in the APB timer datapath between the prescaler (count enable) and the control/status register block (load, clear, reload writes, flag capture).

---
 rtl/tcnt_pkg.sv | 31 +++
 rtl/tcnt_step.sv | 46 ++++
 rtl/tcnt_updown.sv | 115 +++++++++++
 tb/tb_tcnt_updown.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tcnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcnt_pkg
// Brief    : Shared types and constants for the tcnt_updown timer counter.
// Revision : 1.0 - initial release
// ============================================================================

package tcnt_pkg;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_dir_e;

    localparam int unsigned TCNT_WIDTH_DEF = 8;

    // All-ones pattern of the given width, right-aligned in 32 bits.
    function automatic logic [31:0] TCNT_CMP_RST(input int unsigned width);
        logic [31:0] v;
        v = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tcnt_step.sv
`default_nettype none
// ============================================================================
// Module   : tcnt_step
// Brief    : Combinational next-value and wrap detection for tcnt_updown.
// Revision : 1.0 - initial release
// ============================================================================

module tcnt_step
    import tcnt_pkg::*;
#(
    parameter int unsigned WIDTH = TCNT_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_dir,
    input  logic             i_auto_rld,
    input  logic [WIDTH-1:0] i_reload,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap_up,
    output logic             o_wrap_dn
);

    localparam logic [WIDTH-1:0] c_max  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic w_up;
    logic w_dn;

    assign w_up      = (cnt_dir_e'(i_dir) == CNT_UP);
    assign w_dn      = (cnt_dir_e'(i_dir) == CNT_DOWN);
    assign o_wrap_up = w_up && (i_count == c_max);
    assign o_wrap_dn = w_dn && (i_count == c_zero);

    always_comb begin
        o_next = w_up ? (i_count + c_one) : (i_count - c_one);
        // Without auto-reload the wrap lands on the natural opposite bound.
        if (o_wrap_up) begin
            o_next = i_auto_rld ? i_reload : c_zero;
        end else if (o_wrap_dn) begin
            o_next = i_auto_rld ? i_reload : c_max;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tcnt_updown.sv
`default_nettype none
// ============================================================================
// Module   : tcnt_updown
// Brief    : Parametrised up/down timer counter with auto-reload and
//            overflow/underflow pulses. Optional compare unit enabled by
//            defining TCNT_UPDOWN_CMP_EN.
// Revision : 1.0 - initial release
// ============================================================================

module tcnt_updown
    import tcnt_pkg::*;
#(
    parameter int unsigned      WIDTH     = TCNT_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
    input  logic             i_clk_sys,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_wr_cnt,
    input  logic             i_wr_rld,
    input  logic             i_cnt_en,
    input  logic             i_dir,
    input  logic             i_auto_rld,
    input  logic [WIDTH-1:0] i_datain,
`ifdef TCNT_UPDOWN_CMP_EN
    input  logic             i_wr_cmp,
    output logic [WIDTH-1:0] o_cmp,
    output logic             o_cmp_match,
`endif
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_reload,
    output logic             o_ovf,
    output logic             o_udf
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_ovf;
    logic             r_udf;

    logic [WIDTH-1:0] w_next;
    logic             w_wrap_up;
    logic             w_wrap_dn;
    logic             w_step;

    tcnt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_count    (r_count),
        .i_dir      (i_dir),
        .i_auto_rld (i_auto_rld),
        .i_reload   (r_reload),
        .o_next     (w_next),
        .o_wrap_up  (w_wrap_up),
        .o_wrap_dn  (w_wrap_dn)
    );

    // A count step only happens when no clear or load overrides it.
    assign w_step = i_cnt_en & ~i_clr & ~i_wr_cnt;

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            r_count  <= RST_VALUE;
            r_reload <= RST_VALUE;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_ovf <= w_step & w_wrap_up;
            r_udf <= w_step & w_wrap_dn;
            if (i_wr_rld) begin
                r_reload <= i_datain;
            end
            if (i_clr) begin
                r_count <= '0;
            end else if (i_wr_cnt) begin
                r_count <= i_datain;
            end else if (i_cnt_en) begin
                r_count <= w_next;
            end
        end
    end

`ifdef TCNT_UPDOWN_CMP_EN
    localparam logic [WIDTH-1:0] c_cmp_rst = WIDTH'(TCNT_CMP_RST(WIDTH));

    logic [WIDTH-1:0] r_cmp;
    logic             r_cmp_match;

    // Match is judged against the compare value held before this edge.
    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            r_cmp       <= c_cmp_rst;
            r_cmp_match <= 1'b0;
        end else begin
            r_cmp_match <= w_step & (w_next == r_cmp);
            if (i_wr_cmp) begin
                r_cmp <= i_datain;
            end
        end
    end

    assign o_cmp       = r_cmp;
    assign o_cmp_match = r_cmp_match;
`else
    // Compare unit absent: no extra state or ports.
`endif

    assign o_count  = r_count;
    assign o_reload = r_reload;
    assign o_ovf    = r_ovf;
    assign o_udf    = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_tcnt_updown.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcnt_updown
// Brief    : Self-checking bench for tcnt_updown, 8-bit and 4-bit instances
//            driven in lockstep; compare checks when TCNT_UPDOWN_CMP_EN is set.
// Revision : 1.0 - initial release
// ============================================================================

module tb_tcnt_updown;

    logic       clk = 1'b0;
    logic       rst_n, clr, wr_cnt, wr_rld, en, dir, ar;
    logic [7:0] datain;
    logic [7:0] count8, reload8;
    logic [3:0] count4, reload4;
    logic       ovf8, udf8, ovf4, udf4;
`ifdef TCNT_UPDOWN_CMP_EN
    logic       wr_cmp;
    logic [7:0] cmp8;
    logic [3:0] cmp4;
    logic       match8, match4;
`endif

    always #5 clk = ~clk;

    tcnt_updown #(.WIDTH(8), .RST_VALUE(8'h00)) dut8 (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr_cnt(wr_cnt),
        .i_wr_rld(wr_rld), .i_cnt_en(en), .i_dir(dir), .i_auto_rld(ar),
        .i_datain(datain),
`ifdef TCNT_UPDOWN_CMP_EN
        .i_wr_cmp(wr_cmp), .o_cmp(cmp8), .o_cmp_match(match8),
`endif
        .o_count(count8), .o_reload(reload8), .o_ovf(ovf8), .o_udf(udf8)
    );

    tcnt_updown #(.WIDTH(4), .RST_VALUE(4'h0)) dut4 (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr_cnt(wr_cnt),
        .i_wr_rld(wr_rld), .i_cnt_en(en), .i_dir(dir), .i_auto_rld(ar),
        .i_datain(datain[3:0]),
`ifdef TCNT_UPDOWN_CMP_EN
        .i_wr_cmp(wr_cmp), .o_cmp(cmp4), .o_cmp_match(match4),
`endif
        .o_count(count4), .o_reload(reload4), .o_ovf(ovf4), .o_udf(udf4)
    );

    typedef struct {
        string tag;
        int    c8, r8, m8, c4, r4, m4;
        bit    ov8, ud8, mt8, ov4, ud4, mt4;
    } exp_t;

    exp_t sb[$];
    int   m_cnt[2];
    int   m_rld[2];
    int   m_cmp[2];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference model of one counter instance (k=0: 8-bit, k=1: 4-bit).
    task automatic model(input int k, input bit rs, cl, wc, wr, wm, stb, dv, arv,
                         input int d, output int oc, orl, ocm, output bit ov, ud, mt);
        int mx;
        int dk;
        int nc;
        int nr;
        int nm;
        mx = (k == 0) ? 255 : 15;
        dk = d & mx;
        nc = m_cnt[k];
        nr = m_rld[k];
        nm = m_cmp[k];
        ov = 1'b0;
        ud = 1'b0;
        mt = 1'b0;
        if (!rs) begin
            nc = 0;
            nr = 0;
            nm = mx;
        end else begin
            if (wr) nr = dk;
            if (wm) nm = dk;
            if (cl) nc = 0;
            else if (wc) nc = dk;
            else if (stb) begin
                if (!dv) begin
                    if (m_cnt[k] == mx) begin
                        nc = arv ? m_rld[k] : 0;
                        ov = 1'b1;
                    end else nc = m_cnt[k] + 1;
                end else begin
                    if (m_cnt[k] == 0) begin
                        nc = arv ? m_rld[k] : mx;
                        ud = 1'b1;
                    end else nc = m_cnt[k] - 1;
                end
                mt = (nc == m_cmp[k]);
            end
        end
        m_cnt[k] = nc;
        m_rld[k] = nr;
        m_cmp[k] = nm;
        oc  = nc;
        orl = nr;
        ocm = nm;
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, " cnt8"}, 32'(count8),  e.c8);
            chk({e.tag, " rld8"}, 32'(reload8), e.r8);
            chk({e.tag, " ovf8"}, 32'(ovf8),    32'(e.ov8));
            chk({e.tag, " udf8"}, 32'(udf8),    32'(e.ud8));
            chk({e.tag, " cnt4"}, 32'(count4),  e.c4);
            chk({e.tag, " rld4"}, 32'(reload4), e.r4);
            chk({e.tag, " ovf4"}, 32'(ovf4),    32'(e.ov4));
            chk({e.tag, " udf4"}, 32'(udf4),    32'(e.ud4));
`ifdef TCNT_UPDOWN_CMP_EN
            chk({e.tag, " cmp8"},   32'(cmp8),   e.m8);
            chk({e.tag, " match8"}, 32'(match8), 32'(e.mt8));
            chk({e.tag, " cmp4"},   32'(cmp4),   e.m4);
            chk({e.tag, " match4"}, 32'(match4), 32'(e.mt4));
`endif
        end
    endtask

    // Drive one cycle of stimulus, push the expectation, compare after the edge.
    task automatic step(input string tag, input bit rs, cl, wc, wr, wm, stb, dv, arv,
                        input logic [7:0] d);
        exp_t e;
        rst_n  = rs;
        clr    = cl;
        wr_cnt = wc;
        wr_rld = wr;
        en     = stb;
        dir    = dv;
        ar     = arv;
        datain = d;
`ifdef TCNT_UPDOWN_CMP_EN
        wr_cmp = wm;
`endif
        e.tag = tag;
        model(0, rs, cl, wc, wr, wm, stb, dv, arv, int'(d), e.c8, e.r8, e.m8, e.ov8, e.ud8, e.mt8);
        model(1, rs, cl, wc, wr, wm, stb, dv, arv, int'(d), e.c4, e.r4, e.m4, e.ov4, e.ud4, e.mt4);
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //    tag          rs cl wc wr wm en dv ar data
        step("reset0",     0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step("reset1",     0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        rst_n = 1'b1;
        #2;
        chk("rst_release_hold cnt8", 32'(count8), 32'h0);

        step("ld_fe",      1, 0, 1, 0, 0, 0, 0, 0, 8'hFE);
        step("up_ff",      1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step("up_wrap",    1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step("up_01",      1, 0, 0, 0, 0, 1, 0, 0, 8'h00);

        step("wr_rld10",   1, 0, 0, 1, 0, 0, 0, 0, 8'h10);
        step("ld_01",      1, 0, 1, 0, 0, 0, 0, 0, 8'h01);
        step("dn_00",      1, 0, 0, 0, 0, 1, 1, 1, 8'h00);
        step("dn_rld",     1, 0, 0, 0, 0, 1, 1, 1, 8'h00);
        step("dn_b2b",     1, 0, 0, 0, 0, 1, 1, 1, 8'h00);
        step("ld_00",      1, 0, 1, 0, 0, 0, 0, 0, 8'h00);
        step("dn_natural", 1, 0, 0, 0, 0, 1, 1, 0, 8'h00);

        step("ld_ff",      1, 0, 1, 0, 0, 0, 0, 0, 8'hFF);
        step("prio_clr",   1, 1, 1, 0, 0, 1, 0, 0, 8'h55);
        step("ld_55",      1, 0, 1, 0, 0, 0, 0, 0, 8'h55);

        step("wr_rld20",   1, 0, 0, 1, 0, 0, 0, 0, 8'h20);
        step("ld_ff2",     1, 0, 1, 0, 0, 0, 0, 0, 8'hFF);
        step("race_wrap",  1, 0, 0, 1, 0, 1, 0, 1, 8'h30);
        step("ld_ff3",     1, 0, 1, 0, 0, 0, 0, 0, 8'hFF);
        step("wrap_new",   1, 0, 0, 0, 0, 1, 0, 1, 8'h00);
        step("dir_flip",   1, 0, 0, 0, 0, 1, 1, 1, 8'h00);
        step("hold",       1, 0, 0, 0, 0, 0, 0, 0, 8'hAA);

        step("ld_ff4",     1, 0, 1, 0, 0, 0, 0, 0, 8'hFF);
        step("wr_on_wrap", 1, 0, 1, 0, 0, 1, 0, 0, 8'h80);
        step("ld_ff5",     1, 0, 1, 0, 0, 0, 0, 0, 8'hFF);
        step("rst_on_wrap",0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step("post_rst",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00);

`ifdef TCNT_UPDOWN_CMP_EN
        step("wr_cmp03",   1, 0, 0, 0, 1, 0, 0, 0, 8'h03);
        step("ld_01c",     1, 0, 1, 0, 0, 0, 0, 0, 8'h01);
        step("up_02",      1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step("up_03_hit",  1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step("up_04",      1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step("ld_03_nohit",1, 0, 1, 0, 0, 0, 0, 0, 8'h03);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
